instruction_decode_stage: RTL
=============================

// Module: instruction_decode_stage
// PURPOSE
//  Registered, handshaked decode stage between fetch and execute. Decodes a 32-bit instruction
//  (opcode [31:26]) into register addresses, extended immediate, ALU opcode and datapath mux controls.
//  Adds a one-entry output buffer with valid/ready flow control, a RUN/HALTED/TRAP state machine,
//  illegal-opcode trapping, flush, and a decoded-instruction counter.
// PARAMETERS
//  DATA_W     32  width of imm_ext; must be >= 16
//  IMM_SIGNED 1   1: sign-extend instruction[15:0] to DATA_W; 0: zero-extend
//  ALU_OP_W   5   alu_opcode width; must be >= 5; upper bits above [4:0] are always 0
//  CNT_W      32  width of decode_count
// PORTS
//  clk               in   1        clock, rising edge
//  rst               in   1        synchronous reset, active-high
//  flush             in   1        discard buffered decode (branch redirect)
//  resume            in   1        leave HALTED/TRAP and return to RUN
//  in_valid          in   1        instruction valid from fetch
//  in_ready          out  1        stage can accept this cycle
//  instruction       in   32       instruction word
//  out_valid         out  1        decoded bundle valid
//  out_ready         in   1        execute accepts bundle
//  reg1,reg2,reg3    out  5 each   source 1, source 2, destination register addresses
//  s_r_amount        out  5        shift/rotate amount
//  imm_ext           out  DATA_W   extended immediate
//  alu_opcode        out  ALU_OP_W ALU operation
//  write_enable      out  1        register file write
//  jump_mux_signal, write_back_on_register_mux_signal, alu_input_mux_signal  out 1 each: datapath muxes
//  pc_enable         out  1        PC advance enable
//  trap              out  1        illegal opcode trapped
//  trap_insn         out  32       offending instruction word
//  decode_count      out  CNT_W    legal instructions accepted, wraps
// BEHAVIOUR
//  - Reset: all outputs 0 except pc_enable=1 and in_ready per the rule below; state=RUN.
//    Reset has priority over every other input.
//  - pc_enable = (state==RUN). trap = (state==TRAP).
//  - in_ready = (state==RUN) && !flush && (!out_valid || out_ready).
//  - Accept = in_valid && in_ready. All decoded fields register on accept; latency is 1 cycle
//    (out_valid high the cycle after accept).
//  - If out_valid && out_ready with no new accept: out_valid drops to 0 next cycle.
//    Fields hold their last values while out_valid=0.
//  - Opcode classes and decode (op=instruction[31:26]):
//    0: HALT. No bundle; state -> HALTED.
//    1..15: R-type. reg3=[25:21], reg1=[20:16], reg2=[15:11], s_r_amount=[10:6],
//      alu_opcode=op[3:0], write_enable=1, jump=0, wb=1, alu_in=0.
//    18..23: I-type ALU. reg3=[25:21], reg1=[20:16], reg2=0, s_r=0.
//      alu_opcode 18->1, 19->2, 20->3, 21->4, 22->9, 23->10.
//      write_enable=1, jump=0, wb=1, alu_in=1.
//    24..25: load. reg1=reg3=[25:21], reg2=[20:16], alu_opcode=1, write_enable=1,
//      jump=0, wb=0, alu_in=1.
//    26..27: store. Fields as load but write_enable=0.
//    30/31: branch. reg1=[25:21], reg2=[20:16], reg3=0, alu_opcode 16/17,
//      write_enable=0, jump=1, wb=1, alu_in=0.
//    All others (16, 17, 28, 29, 32..63): illegal. No bundle; trap_insn<=instruction;
//      state -> TRAP.
//  - imm_ext = instruction[15:0] extended per IMM_SIGNED; it is loaded for every legal class.
//  - decode_count increments by 1 per accepted legal instruction; HALT/illegal do not count;
//    wraps 2^CNT_W-1 -> 0.
//  - FSM: RUN -(accept HALT)-> HALTED; RUN -(accept illegal)-> TRAP;
//    HALTED/TRAP -(resume)-> RUN next cycle. resume in RUN is ignored.
//    Entering HALTED/TRAP does not clear an already-buffered bundle; it drains normally.
//  - flush: out_valid <= 0 next cycle, no accept this cycle, state unchanged.
//    flush with out_valid && out_ready in the same cycle counts as dropped (execute ignores it).
// TESTING
//  - Reset then in_valid with op=3 word 0x0C43_2A80, out_ready=1 -> next cycle out_valid=1,
//    reg3=2, reg1=3, reg2=5, s_r=10, alu_opcode=3, write_enable=1, decode_count=1.
//  - op=22 with imm 0x8001, IMM_SIGNED=1, DATA_W=32 -> imm_ext=0xFFFF_8001, alu_opcode=9,
//    alu_in=1; rerun with IMM_SIGNED=0 -> 0x0000_8001.
//  - out_ready=0 with bundle held, in_valid=1 -> in_ready=0, bundle stable;
//    raise out_ready -> new bundle accepted the same cycle and appears the next cycle.
//  - Accept word 0x0000_0000 -> no out_valid, pc_enable=0 and in_ready=0 next cycle;
//    pulse resume -> pc_enable=1 the following cycle.
//  - Accept op=17 word 0x4400_1234 -> trap=1, trap_insn=0x4400_1234, decode_count unchanged;
//    resume clears trap.
//  - flush while out_valid=1 and out_ready=1 -> out_valid=0 next cycle; assert rst mid-halt
//    -> RUN, all outputs 0, pc_enable=1; CNT_W=2 bench wraps count 3 -> 0.

Source files
------------

// File: rtl/instruction_decode_stage.sv
// Registered decode stage between fetch and execute. One-entry output buffer with
// valid/ready flow control, RUN/HALTED/TRAP state machine, illegal-opcode trap, flush,
// and a running count of accepted legal instructions.
module instruction_decode_stage #(
   parameter int unsigned DATA_W     = 32,
   parameter bit          IMM_SIGNED = 1'b1,
   parameter int unsigned ALU_OP_W   = 5,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_flush,
   input  logic                i_resume,
   input  logic                i_in_valid,
   output logic                o_in_ready,
   input  logic [31:0]         i_instruction,
   output logic                o_out_valid,
   input  logic                i_out_ready,
   output logic [4:0]          o_reg1,
   output logic [4:0]          o_reg2,
   output logic [4:0]          o_reg3,
   output logic [4:0]          o_s_r_amount,
   output logic [DATA_W-1:0]   o_imm_ext,
   output logic [ALU_OP_W-1:0] o_alu_opcode,
   output logic                o_write_enable,
   output logic                o_jump_mux_signal,
   output logic                o_write_back_on_register_mux_signal,
   output logic                o_alu_input_mux_signal,
   output logic                o_pc_enable,
   output logic                o_trap,
   output logic [31:0]         o_trap_insn,
   output logic [CNT_W-1:0]    o_decode_count
);

   typedef enum logic [1:0] {StRun, StHalted, StTrap} state_e;

   state_e              r_state;
   state_e              w_state_next;

   logic [5:0]          w_op;
   logic                w_halt, w_legal, w_illegal;
   logic                w_accept, w_accept_legal, w_in_ready;
   logic [4:0]          w_reg1, w_reg2, w_reg3, w_sr, w_alu;
   logic                w_we, w_jump, w_wb, w_ain;
   logic [DATA_W-1:0]   w_imm;

   logic                r_out_valid;
   logic [4:0]          r_reg1, r_reg2, r_reg3, r_sr;
   logic [DATA_W-1:0]   r_imm;
   logic [ALU_OP_W-1:0] r_alu;
   logic                r_we, r_jump, r_wb, r_ain;
   logic [31:0]         r_trap_insn;
   logic [CNT_W-1:0]    r_decode_count;

   assign w_op           = i_instruction[31:26];
   assign w_illegal      = !w_legal && !w_halt;
   assign w_accept       = i_in_valid && w_in_ready;
   assign w_accept_legal = w_accept && w_legal;

   // Immediate extension; loop form keeps DATA_W == 16 legal.
   always_comb begin
      w_imm       = '0;
      w_imm[15:0] = i_instruction[15:0];
      for (int i = 16; i < DATA_W; i++) begin
         w_imm[i] = IMM_SIGNED & i_instruction[15];
      end
   end

   // Opcode class decode into bundle fields.
   always_comb begin
      w_halt  = (w_op == 6'd0);
      w_legal = 1'b1;
      w_reg1  = '0;
      w_reg2  = '0;
      w_reg3  = '0;
      w_sr    = '0;
      w_alu   = '0;
      w_we    = 1'b0;
      w_jump  = 1'b0;
      w_wb    = 1'b0;
      w_ain   = 1'b0;
      case (w_op) inside
         6'd0: w_legal = 1'b0;
         [6'd1:6'd15]: begin
            w_reg3 = i_instruction[25:21];
            w_reg1 = i_instruction[20:16];
            w_reg2 = i_instruction[15:11];
            w_sr   = i_instruction[10:6];
            w_alu  = {1'b0, w_op[3:0]};
            w_we   = 1'b1;
            w_wb   = 1'b1;
         end
         [6'd18:6'd23]: begin
            w_reg3 = i_instruction[25:21];
            w_reg1 = i_instruction[20:16];
            w_we   = 1'b1;
            w_wb   = 1'b1;
            w_ain  = 1'b1;
            case (w_op)
               6'd18:   w_alu = 5'd1;
               6'd19:   w_alu = 5'd2;
               6'd20:   w_alu = 5'd3;
               6'd21:   w_alu = 5'd4;
               6'd22:   w_alu = 5'd9;
               default: w_alu = 5'd10;
            endcase
         end
         // Loads (24,25) write back from memory; stores (26,27) do not write.
         [6'd24:6'd27]: begin
            w_reg1 = i_instruction[25:21];
            w_reg3 = i_instruction[25:21];
            w_reg2 = i_instruction[20:16];
            w_alu  = 5'd1;
            w_we   = ~w_op[1];
            w_ain  = 1'b1;
         end
         6'd30, 6'd31: begin
            w_reg1 = i_instruction[25:21];
            w_reg2 = i_instruction[20:16];
            w_alu  = {4'b1000, w_op[0]};
            w_jump = 1'b1;
            w_wb   = 1'b1;
         end
         default: w_legal = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= StRun;
      else       r_state <= w_state_next;
   end

   // Next-state logic.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StRun: begin
            if (w_accept && w_halt)         w_state_next = StHalted;
            else if (w_accept && w_illegal) w_state_next = StTrap;
         end
         StHalted, StTrap: begin
            if (i_resume) w_state_next = StRun;
         end
         default: w_state_next = StRun;
      endcase
   end

   // State-derived outputs and input handshake.
   always_comb begin
      o_pc_enable = (r_state == StRun);
      o_trap      = (r_state == StTrap);
      w_in_ready  = (r_state == StRun) && !i_flush && (!r_out_valid || i_out_ready);
   end

   // Output buffer, trap capture and counter.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_out_valid    <= 1'b0;
         r_reg1         <= '0;
         r_reg2         <= '0;
         r_reg3         <= '0;
         r_sr           <= '0;
         r_imm          <= '0;
         r_alu          <= '0;
         r_we           <= 1'b0;
         r_jump         <= 1'b0;
         r_wb           <= 1'b0;
         r_ain          <= 1'b0;
         r_trap_insn    <= '0;
         r_decode_count <= '0;
      end else begin
         if (i_flush)                         r_out_valid <= 1'b0;
         else if (w_accept_legal)             r_out_valid <= 1'b1;
         else if (r_out_valid && i_out_ready) r_out_valid <= 1'b0;
         if (w_accept_legal) begin
            r_reg1         <= w_reg1;
            r_reg2         <= w_reg2;
            r_reg3         <= w_reg3;
            r_sr           <= w_sr;
            r_imm          <= w_imm;
            r_alu          <= ALU_OP_W'(w_alu);
            r_we           <= w_we;
            r_jump         <= w_jump;
            r_wb           <= w_wb;
            r_ain          <= w_ain;
            r_decode_count <= r_decode_count + CNT_W'(1);
         end
         if (w_accept && w_illegal) r_trap_insn <= i_instruction;
      end
   end

   assign o_in_ready                          = w_in_ready;
   assign o_out_valid                         = r_out_valid;
   assign o_reg1                              = r_reg1;
   assign o_reg2                              = r_reg2;
   assign o_reg3                              = r_reg3;
   assign o_s_r_amount                        = r_sr;
   assign o_imm_ext                           = r_imm;
   assign o_alu_opcode                        = r_alu;
   assign o_write_enable                      = r_we;
   assign o_jump_mux_signal                   = r_jump;
   assign o_write_back_on_register_mux_signal = r_wb;
   assign o_alu_input_mux_signal              = r_ain;
   assign o_trap_insn                         = r_trap_insn;
   assign o_decode_count                      = r_decode_count;

endmodule
